// File: rtl/r_reorder_pkg.sv
// Shared configuration and types for the AXI R reorder unit.
// Widths and depths for the whole slice are fixed here.
package r_reorder_pkg;

    localparam int ID_WIDTH   = 4;
    localparam int DATA_WIDTH = 64;
    localparam int RESP_WIDTH = 2;
    localparam int NUM_TAGS   = 8;
    localparam int MAX_BEATS  = 16;

    localparam int TAG_W  = $clog2(NUM_TAGS);
    localparam int BC_W   = $clog2(MAX_BEATS + 1);
    localparam int SLOT_W = $clog2(MAX_BEATS);

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [BC_W-1:0]  bcnt_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [RESP_WIDTH-1:0] resp;
        logic                  last;
    } r_beat_t;

    typedef struct packed {
        logic                busy;
        logic [ID_WIDTH-1:0] orig_id;
        logic                done;
    } tag_entry_t;

    function automatic tag_t next_ptr(input tag_t p);
        return (p == tag_t'(NUM_TAGS - 1)) ? '0 : p + tag_t'(1);
    endfunction

endpackage

// File: rtl/r_if.sv
// AXI R channel bundle: sender drives the beat, receiver drives ready.
interface r_if #(
    parameter int ID_W   = r_reorder_pkg::ID_WIDTH,
    parameter int DATA_W = r_reorder_pkg::DATA_WIDTH,
    parameter int RESP_W = r_reorder_pkg::RESP_WIDTH
) ();
    logic              valid;
    logic              ready;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [RESP_W-1:0] resp;
    logic              last;

    modport sender   (output valid, id, data, resp, last, input ready);
    modport receiver (input valid, id, data, resp, last, output ready);
endinterface

// File: rtl/r_reorder_unit_tag_order_fifo.sv
// NUM_TAGS-deep FIFO of tags recording allocation order; it holds at most
// one entry per tag, so it can never overflow.
module tag_order_fifo
    import r_reorder_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  tag_t push_tag_i,
    input  logic pop_i,
    output tag_t head_o,
    output logic empty_o
);

    tag_t             mem_q [NUM_TAGS];
    tag_t             wr_ptr_q;
    tag_t             rd_ptr_q;
    logic [TAG_W:0]   count_q;

    // NOTE: storage is not reset; an entry is only read after count_q shows it was written.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_tag_i;
    end

    // NOTE: non-blocking assignments, so every term here reads the pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/r_reorder_unit.sv
// Reorders out-of-order AXI R bursts back into tag allocation order.
// Optional protocol checking is enabled with macro R_REORDER_ERR_CHECK_EN.
module r_reorder_unit
    import r_reorder_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_valid,
    input  logic [ID_WIDTH-1:0] alloc_orig_id,
    output logic                alloc_ready,
    output tag_t                alloc_tag,
    r_if.receiver               r_in,
    r_if.sender                 r_out,
    output logic                err
);

    tag_entry_t tag_tbl_q [NUM_TAGS];
    bcnt_t      wr_cnt_q  [NUM_TAGS];
    r_beat_t    slot_q    [NUM_TAGS][MAX_BEATS];
    bcnt_t      rd_cnt_q, rd_cnt_d;

    logic    free_any;
    tag_t    free_tag;
    logic    alloc_fire;
    tag_t    in_tag;
    logic    in_hit, in_ok, in_wr;
    tag_t    head;
    logic    fifo_empty;
    r_beat_t head_beat;
    logic    out_valid, out_fire, out_pop;

    always_comb begin
        // NOTE: defaults first, so no path through the loop leaves an output unassigned.
        free_any = 1'b0;
        free_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!tag_tbl_q[i].busy) begin
                free_any = 1'b1;
                free_tag = tag_t'(i);
            end
        end
    end

    assign alloc_ready = ~rst & free_any;
    assign alloc_tag   = free_tag;
    assign alloc_fire  = alloc_valid & alloc_ready;

    assign r_in.ready = ~rst;
    assign in_tag     = r_in.id[TAG_W-1:0];
    assign in_hit     = r_in.valid & r_in.ready;
    assign in_wr      = in_hit & in_ok;

`ifdef R_REORDER_ERR_CHECK_EN
    logic err_q;

    assign in_ok = tag_tbl_q[in_tag].busy & ~tag_tbl_q[in_tag].done
                 & (wr_cnt_q[in_tag] < bcnt_t'(MAX_BEATS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 err_q <= 1'b0;
        else if (in_hit & ~in_ok) err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign in_ok = 1'b1;
    assign err   = 1'b0;
`endif

    tag_order_fifo u_order (
        .clk        (clk),
        .rst        (rst),
        .push_i     (alloc_fire),
        .push_tag_i (alloc_tag),
        .pop_i      (out_pop),
        .head_o     (head),
        .empty_o    (fifo_empty)
    );

    assign head_beat = slot_q[head][rd_cnt_q[SLOT_W-1:0]];
    assign out_valid = ~fifo_empty & (wr_cnt_q[head] > rd_cnt_q);
    assign out_fire  = out_valid & r_out.ready;
    assign out_pop   = out_fire & head_beat.last;

    assign r_out.valid = out_valid;
    assign r_out.id    = tag_tbl_q[head].orig_id;
    assign r_out.data  = head_beat.data;
    assign r_out.resp  = head_beat.resp;
    assign r_out.last  = head_beat.last;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (out_pop)       rd_cnt_d = '0;
        else if (out_fire) rd_cnt_d = rd_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (in_wr) begin
            slot_q[in_tag][wr_cnt_q[in_tag][SLOT_W-1:0]] <= '{data: r_in.data, resp: r_in.resp, last: r_in.last};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q <= '0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                tag_tbl_q[i] <= '0;
                wr_cnt_q[i]  <= '0;
            end
        end else begin
            rd_cnt_q <= rd_cnt_d;
            if (alloc_fire) begin
                tag_tbl_q[alloc_tag].busy    <= 1'b1;
                tag_tbl_q[alloc_tag].orig_id <= alloc_orig_id;
                tag_tbl_q[alloc_tag].done    <= 1'b0;
            end
            if (in_wr) begin
                wr_cnt_q[in_tag] <= wr_cnt_q[in_tag] + 1'b1;
                if (r_in.last) tag_tbl_q[in_tag].done <= 1'b1;
            end
            // Release comes last so it overrides anything else aimed at the head tag.
            if (out_pop) begin
                tag_tbl_q[head].busy <= 1'b0;
                tag_tbl_q[head].done <= 1'b0;
                wr_cnt_q[head]       <= '0;
            end
        end
    end

endmodule
